// File: rtl/mux_arb.sv
// Wormhole-locking round-robin arbiter for the 2:1 flit mux: grants on HEAD, holds until TAIL.
// Optional idle-lock watchdog enabled by defining MUX_ARB_WDOG_EN.
module mux_arb #(
  parameter int SELW    = 5,
  parameter int TYPEW   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             ordy,
  output logic [SELW-1:0]  sel,
  output logic             ipop_0,
  output logic             ipop_1,
  output logic             busy,
  output logic             err
);

  // State encoding doubles as the one-hot mux select.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_e;

  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             req0, req1;
  logic             lk_pop;
  logic [TYPEW-1:0] lk_type;

`ifdef MUX_ARB_WDOG_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);
  logic [7:0] wdog_q, wdog_d;
  logic       lk_valid;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign sel    = {{(SELW-2){1'b0}}, state_q};
  assign busy   = (state_q != IDLE);
  assign err    = err_q;
  assign ipop_0 = (state_q == LOCK0) && ivalid_0 && ordy;
  assign ipop_1 = (state_q == LOCK1) && ivalid_1 && ordy;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    first_d = first_q;
    err_d   = err_q;
    req0    = ivalid_0 && (itype_0 == T_HEAD);
    req1    = ivalid_1 && (itype_1 == T_HEAD);
    lk_pop  = ipop_0 || ipop_1;
    lk_type = (state_q == LOCK0) ? itype_0 : itype_1;

    case (state_q)
      IDLE: begin
        if ((ivalid_0 && !req0) || (ivalid_1 && !req1))
          err_d = 1'b1;
        first_d = 1'b1;
        if (req0 && (!req1 || !prio_q))
          state_d = LOCK0;
        else if (req1)
          state_d = LOCK1;
      end
      LOCK0, LOCK1: begin
        if (lk_pop) begin
          first_d = 1'b0;
          // A second HEAD inside a locked packet is flagged but the lock is kept.
          if ((lk_type == T_HEAD) && !first_q)
            err_d = 1'b1;
          if (lk_type == T_TAIL) begin
            state_d = IDLE;
            prio_d  = (state_q == LOCK0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MUX_ARB_WDOG_EN
    lk_valid = (state_q == LOCK0) ? ivalid_0 : ivalid_1;
    wdog_d   = 8'd0;
    if ((state_q != IDLE) && !lk_valid) begin
      wdog_d = wdog_q + 8'd1;
      if (wdog_d == WDOG_LIMIT) begin
        state_d = IDLE;
        err_d   = 1'b1;
        prio_d  = ~prio_q;
        wdog_d  = 8'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MUX_ARB_WDOG_EN
      wdog_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      first_q <= first_d;
      err_q   <= err_d;
`ifdef MUX_ARB_WDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: a packet-level owner model predicts each cycle's outputs.
`timescale 1ns/1ps
module tb_mux_arb;
  localparam int TO = 16;
  localparam logic [1:0] NONE = 2'd0, HEAD = 2'd1, DATA = 2'd2, TAIL = 2'd3;

  logic       clk = 1'b0;
  logic       rst, ivalid_0, ivalid_1, ordy;
  logic [1:0] itype_0, itype_1;
  logic [4:0] sel;
  logic       ipop_0, ipop_1, busy, err;

  mux_arb #(.SELW(5), .TYPEW(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy), .sel(sel), .ipop_0(ipop_0), .ipop_1(ipop_1),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    bit busy, err, pop0, pop1;
  } exp_t;

  exp_t       expq[$];
  logic [1:0] q0[$], q1[$];
  int         glog[$];
  int         n_chk = 0, n_fail = 0;
  int         n_pop0 = 0, n_pop1 = 0, n_sel2 = 0;
  int         vp = 100;
  bit         rnd_ordy = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: who owns the output, who is favoured next, sticky error.
  initial begin
    int own, rr, wcnt, t, v;
    bit err_m, first_m, armed, r0, r1;
    exp_t e;
    own = -1; rr = 0; wcnt = 0; err_m = 0; first_m = 0; armed = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        e.sel  = (own == 0) ? 1 : (own == 1) ? 2 : 0;
        e.busy = (own >= 0);
        e.err  = err_m;
        e.pop0 = (own == 0) && ivalid_0 && ordy;
        e.pop1 = (own == 1) && ivalid_1 && ordy;
        expq.push_back(e);
      end
      if (rst) begin
        own = -1; rr = 0; wcnt = 0; err_m = 0; first_m = 0; armed = 1;
      end else if (armed) begin
        if (own < 0) begin
          wcnt = 0;
          if ((ivalid_0 && itype_0 != HEAD) || (ivalid_1 && itype_1 != HEAD)) err_m = 1;
          r0 = ivalid_0 && itype_0 == HEAD;
          r1 = ivalid_1 && itype_1 == HEAD;
          if (r0 && r1) own = rr;
          else if (r0) own = 0;
          else if (r1) own = 1;
          first_m = 1;
        end else begin
          v = (own == 0) ? int'(ivalid_0) : int'(ivalid_1);
          t = (own == 0) ? int'(itype_0) : int'(itype_1);
          if (v != 0 && ordy) begin
            if (t == HEAD && !first_m) err_m = 1;
            first_m = 0;
            if (t == TAIL) begin
              rr = 1 - own;
              own = -1;
            end
          end
`ifdef MUX_ARB_WDOG_EN
          if (own >= 0) begin
            if (v != 0) wcnt = 0;
            else begin
              wcnt++;
              if (wcnt == TO) begin
                own = -1; err_m = 1; rr = 1 - rr; wcnt = 0;
              end
            end
          end
`endif
        end
      end
    end
  end

  // Monitor: compare the DUT against each predicted cycle.
  initial begin
    exp_t e;
    bit   busy_prev;
    busy_prev = 0;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sel", 32'(sel), e.sel);
        chk("busy", 32'(busy), 32'(e.busy));
        chk("err", 32'(err), 32'(e.err));
        chk("ipop_0", 32'(ipop_0), 32'(e.pop0));
        chk("ipop_1", 32'(ipop_1), 32'(e.pop1));
        if (ipop_0 === 1'b1) n_pop0++;
        if (ipop_1 === 1'b1) n_pop1++;
        if (sel === 5'd2) n_sel2++;
        if (busy === 1'b1 && !busy_prev) glog.push_back((sel === 5'd2) ? 1 : 0);
        busy_prev = (busy === 1'b1);
      end
    end
  end

  task automatic add_pkt(int port, int len);
    logic [1:0] f;
    for (int i = 0; i < len; i++) begin
      f = (i == 0) ? HEAD : (i == len - 1) ? TAIL : DATA;
      if (port == 0) q0.push_back(f); else q1.push_back(f);
    end
  endtask

  // One clock: retire flits the DUT popped, then present the next front flits.
  task automatic step();
    logic p0, p1;
    @(negedge clk);
    #2;
    p0 = ipop_0;
    p1 = ipop_1;
    @(posedge clk);
    if (p0 === 1'b1 && q0.size() > 0) q0.delete(0);
    if (p1 === 1'b1 && q1.size() > 0) q1.delete(0);
    #1;
    if (rnd_ordy) ordy = ($urandom_range(99) < 75);
    if (q0.size() > 0 && $urandom_range(99) < vp) begin
      ivalid_0 = 1'b1; itype_0 = q0[0];
    end else begin
      ivalid_0 = 1'b0; itype_0 = NONE;
    end
    if (q1.size() > 0 && $urandom_range(99) < vp) begin
      ivalid_1 = 1'b1; itype_1 = q1[0];
    end else begin
      ivalid_1 = 1'b0; itype_1 = NONE;
    end
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && (q0.size() > 0 || q1.size() > 0); i++) step();
    repeat (3) step();
  endtask

  initial begin
    int n0;
    rst = 1'b1; ivalid_0 = 1'b0; ivalid_1 = 1'b0; itype_0 = NONE; itype_1 = NONE; ordy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step(); #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ipop", 32'({ipop_1, ipop_0}), 0);

    // Single 22-flit packet on input 1.
    n_pop1 = 0; n_sel2 = 0;
    add_pkt(1, 22);
    drain(60);
    chk("t1_drained", 32'(q1.size()), 0);
    chk("t1_pop1_cycles", 32'(n_pop1), 22);
    chk("t1_sel10_cycles", 32'(n_sel2), 22);
    chk("t1_idle_after", 32'(busy), 0);

    // Simultaneous heads: grants alternate starting at input 0.
    glog.delete();
    add_pkt(0, 3); add_pkt(0, 3); add_pkt(1, 3); add_pkt(1, 3);
    drain(80);
    chk("t2_grants", 32'(glog.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_grant_order", (i < glog.size()) ? glog[i] : -1, i % 2);

    // Backpressure mid-packet on input 0.
    add_pkt(0, 8);
    n0 = n_pop0;
    for (int i = 0; i < 20 && n_pop0 - n0 < 3; i++) step();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("t3_stall_sel", 32'(sel), 1);
      chk("t3_stall_pop", 32'(ipop_0), 0);
    end
    ordy = 1'b1;
    drain(40);
    chk("t3_drained", 32'(q0.size()), 0);
    chk("t3_pop_total", 32'(n_pop0 - n0), 8);
    chk("t3_err", 32'(err), 0);

    // DATA flit while idle.
    q0.push_back(DATA);
    step(); step(); #1;
    chk("t4_err", 32'(err), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ipop_0", 32'(ipop_0), 0);
    q0.delete();
    rst = 1'b1; step(); rst = 1'b0; step(); #1;
    chk("t4_err_cleared", 32'(err), 0);

    // Reset mid-packet, then a fresh packet on input 1.
    add_pkt(0, 16);
    n0 = n_pop0;
    for (int i = 0; i < 30 && n_pop0 - n0 < 10; i++) step();
    chk("t5_ten_flits", 32'(n_pop0 - n0), 10);
    q0.delete();
    rst = 1'b1; step(); rst = 1'b0; step(); #1;
    chk("t5_sel", 32'(sel), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_prio", 32'(dut.prio_q), 0);
    glog.delete();
    add_pkt(1, 3);
    drain(30);
    chk("t5_grants", 32'(glog.size()), 1);
    chk("t5_grant_port", (glog.size() > 0) ? glog[0] : -1, 1);

`ifdef MUX_ARB_WDOG_EN
    // Input 0 locks and goes silent; a waiting input-1 head gets through after the timeout.
    q0.push_back(HEAD); q0.push_back(DATA);
    glog.delete();
    repeat (4) step();
    add_pkt(1, 3);
    for (int i = 0; i < 40; i++) step();
    chk("wd_err", 32'(err), 1);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_grants", 32'(glog.size()), 2);
    chk("wd_second_grant", (glog.size() > 1) ? glog[1] : -1, 1);
    q0.delete(); q1.delete();
    rst = 1'b1; step(); rst = 1'b0; step();
`endif

    // Random traffic with gaps and backpressure.
    vp = 70; rnd_ordy = 1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(3) == 0) add_pkt(0, int'($urandom_range(6, 2)));
      if (q1.size() < 3 && $urandom_range(3) == 0) add_pkt(1, int'($urandom_range(6, 2)));
      step();
    end
    vp = 100; rnd_ordy = 0; ordy = 1'b1;
    drain(500);
    chk("rnd_drained", 32'(q0.size() + q1.size()), 0);
    chk("rnd_err", 32'(err), 0);
    chk("rnd_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arb.md
# mux_arb

Packet-aware two-input arbiter that drives the one-hot `sel` of the 2:1 flit mux in the router datapath. It grants one input on a head flit, holds that grant (wormhole lock) until the matching tail flit has been transferred, then re-arbitrates round-robin. It also produces per-input pop strobes so upstream buffers advance only when their flit is actually forwarded.

## Interface
Parameters:
- `SELW`, 5: width of `sel`, matching the mux `PORT_P1` width. Only bits [1:0] are ever driven high.
- `TYPEW`, 2: width of the flit-type field.
- `TIMEOUT`, 16: idle-lock watchdog limit in cycles. Used only under `MUX_ARB_WDOG_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ivalid_0`  in  1  flit valid at input 0.
- `itype_0`  in  TYPEW  flit type at input 0 (NONE=0, HEAD=1, DATA=2, TAIL=3).
- `ivalid_1`  in  1  flit valid at input 1.
- `itype_1`  in  TYPEW  flit type at input 1.
- `ordy`  in  1  downstream can accept a flit this cycle.
- `sel`  out  SELW  one-hot mux select: 'b01 selects input 0, 'b10 selects input 1, 0 means none.
- `ipop_0`  out  1  input 0 flit transferred this cycle.
- `ipop_1`  out  1  input 1 flit transferred this cycle.
- `busy`  out  1  a packet lock is held.
- `err`  out  1  sticky protocol/watchdog error.

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Registered `sel` = 'b00/'b01/'b10 respectively. `busy` = state != IDLE.
- A request on input x is `ivalid_x & itype_x==HEAD`.
- **IDLE:**
  - Only input 0 requests: go to LOCK0.
  - Only input 1 requests: go to LOCK1.
  - Both request: grant the port indicated by the priority pointer `prio`.
  - Neither requests: stay in IDLE.
  - No pops are issued in IDLE.
- **LOCKx:**
  - `ipop_x` = `ivalid_x & ordy`. The other input's pop is 0.
  - On `ipop_x` with `itype_x==TAIL`: go to IDLE and set `prio` to the other port.
  - Otherwise stay in LOCKx.
- **Protocol errors (set `err`):**
  - Non-HEAD valid flit at an input while in IDLE. The flit is ignored.
  - HEAD flit popped while locked to that input and not on the first transfer of the lock. The FSM keeps the lock.
- `err` clears only on `rst`.
- `ordy` low stalls the lock indefinitely. The FSM does not change state.

## Timing
- Reset values (`rst` high at a rising edge): state IDLE, `sel`=0, `prio`=0, `busy`=0, `err`=0, watchdog counter 0. `ipop_0` and `ipop_1` read 0 in the cycle following reset.
- `ipop_x` is combinational from registered state, `ivalid_x` and `ordy`. There is no combinational path from `itype_*` to `sel`.
- Grant latency: a HEAD presented in IDLE at edge t gives `sel` valid after edge t+1. The head is popped in that same cycle if `ordy`=1.
- Back-to-back packets: there is exactly one IDLE bubble cycle between a tail pop and the next head pop.
- Both inputs request continuously: grants strictly alternate, 0, 1, 0, ...
- `rst` asserted mid-packet: the FSM returns to IDLE immediately. The partial packet is abandoned, and after reset the bench must restart from a HEAD.

## Configuration
- Macro: `MUX_ARB_WDOG_EN`.
- **Defined:**
  - An 8-bit counter increments each LOCK cycle with `ivalid_x`=0.
  - The counter clears on any valid at the locked input, and in IDLE.
  - When the counter reaches `TIMEOUT`, the FSM forces IDLE, sets `err`, and flips `prio`.
- **Undefined:** there is no counter, and the lock waits forever.

## Test plan
- **Single packet on input 1:** HEAD + 20 DATA + TAIL on input 1, `ordy`=1.
  - `sel`=0 for one cycle, then 'b10 for 22 cycles.
  - `ipop_1` high for 22 cycles.
  - Back to `sel`=0 the cycle after TAIL.
- **Simultaneous heads after reset:** both inputs send 3-flit packets continuously. Grant order is 0, 1, 0, 1, and each packet is followed by one bubble cycle.
- **Backpressure:** `ordy` dropped for 5 cycles mid-packet on input 0.
  - `sel` holds 'b01, `ipop_0`=0 for those cycles.
  - The packet completes after `ordy` returns.
  - `err` stays 0.
- **Protocol error:** a DATA flit on input 0 while in IDLE gives `err`=1 the next cycle, the state stays IDLE, and `ipop_0`=0.
- **Reset mid-packet:** `rst` is pulsed after 10 flits of input 0.
  - The next cycle shows `sel`=0, `busy`=0, `prio`=0.
  - A fresh HEAD on input 1 is granted normally.
- **Watchdog (`MUX_ARB_WDOG_EN`, `TIMEOUT`=16):** input 0 locks and then deasserts valid.
  - After 16 idle lock cycles: `busy`=0, `err`=1.
  - A pending input-1 HEAD is granted next.
